// File: rtl/tick_period_meter_pkg.sv
// rtl/tick_period_meter_pkg.sv - shared types and sizing helpers for the tick period meter
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam int LOCK_COUNT_DEFAULT = 4;

    // Width of a counter able to hold 0..lock_count inclusive.
    function automatic int match_cnt_width(input int lock_count);
        return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
    endfunction

    localparam int MCW = match_cnt_width(LOCK_COUNT_DEFAULT);

endpackage

// File: rtl/tick_period_meter_if.sv
// rtl/tick_period_meter_if.sv - tick input and measurement result bundle
interface tick_period_meter_if #(
    parameter int W = 32
);
    logic         i_en;
    logic         i_tick;
    logic [W-1:0] o_period;
    logic [W-1:0] o_high;
    logic         o_valid;
    logic         o_timeout;
    logic         o_locked;

    modport master (
        output i_en, i_tick,
        input  o_period, o_high, o_valid, o_timeout, o_locked
    );

    modport slave (
        input  i_en, i_tick,
        output o_period, o_high, o_valid, o_timeout, o_locked
    );
endinterface

// File: rtl/tick_period_meter_edge_det.sv
// rtl/tick_period_meter_edge_det.sv - registered rising-edge detector for a clock-synchronous tick
module tick_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    output logic o_rise
);
    logic tick_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= i_tick;
        end
    end

    assign o_rise = i_tick & ~tick_q;
endmodule

// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - recovers period, high time, timeout and lock of a divided tick
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int W          = 32,
    parameter int MAX_PERIOD = 1000000,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tick_period_meter_if.slave   bus
);
    localparam int            MCWL   = match_cnt_width(LOCK_COUNT);
    localparam logic [W-1:0]  MAXP   = W'(MAX_PERIOD);
    localparam logic [W-1:0]  TOLV   = W'(TOL);
    localparam logic [MCWL-1:0] LOCK_M = MCWL'(LOCK_COUNT);

    state_t          state, state_n;
    logic            rise;
    logic [W-1:0]    cnt, hcnt, prev, diff;
    logic [MCWL-1:0] match_cnt, mc_next;
    logic            have_prev;
    logic            match;
    logic [W-1:0]    period_r, high_r;
    logic            valid_r, timeout_r, locked_r;

    tick_edge_det u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (bus.i_tick),
        .o_rise (rise)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (rise) state_n = ST_MEASURE;
            ST_MEASURE: if (!rise && cnt == MAXP) state_n = ST_TIMEOUT;
            ST_TIMEOUT: if (rise) state_n = ST_MEASURE;
            default:    state_n = ST_IDLE;
        endcase
        if (!bus.i_en) state_n = ST_IDLE;
    end

    always_comb begin
        diff    = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
        match   = (diff <= TOLV);
        mc_next = (match_cnt >= LOCK_M) ? LOCK_M : match_cnt + MCWL'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            hcnt      <= '0;
            prev      <= '0;
            match_cnt <= '0;
            have_prev <= 1'b0;
            period_r  <= '0;
            high_r    <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (!bus.i_en) begin
                cnt       <= '0;
                hcnt      <= '0;
                match_cnt <= '0;
                have_prev <= 1'b0;
                timeout_r <= 1'b0;
                locked_r  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            cnt  <= W'(1);
                            hcnt <= W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (rise) begin
                            period_r  <= cnt;
                            high_r    <= hcnt;
                            valid_r   <= 1'b1;
                            cnt       <= W'(1);
                            hcnt      <= W'(1);
                            prev      <= cnt;
                            have_prev <= 1'b1;
                            // The first period after a restart only seeds prev.
                            if (have_prev) begin
                                if (match) begin
                                    match_cnt <= mc_next;
                                    if (mc_next == LOCK_M) locked_r <= 1'b1;
                                end else begin
                                    match_cnt <= '0;
                                    locked_r  <= 1'b0;
                                end
                            end
                        end else begin
                            cnt  <= cnt + W'(1);
                            hcnt <= hcnt + W'(bus.i_tick);
                            if (cnt == MAXP) begin
                                timeout_r <= 1'b1;
                                locked_r  <= 1'b0;
                                match_cnt <= '0;
                                have_prev <= 1'b0;
                            end
                        end
                    end
                    ST_TIMEOUT: begin
                        if (rise) begin
                            cnt       <= W'(1);
                            hcnt      <= W'(1);
                            timeout_r <= 1'b0;
                        end
                    end
                    default: begin
                        cnt  <= '0;
                        hcnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_period  = period_r;
    assign bus.o_high    = high_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_timeout = timeout_r;
    assign bus.o_locked  = locked_r;
endmodule

// File: tb/tb_tick_period_meter.sv
// tb/tb_tick_period_meter.sv - self-checking bench for tick_period_meter against a timestamp model
module tb_tick_period_meter;
    localparam int W    = 32;
    localparam int MAXP = 20;
    localparam int TOLP = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tick_period_meter_if #(.W(W)) bus_a ();
    tick_period_meter_if #(.W(W)) bus_b ();

    tick_period_meter #(.W(W), .MAX_PERIOD(MAXP), .LOCK_COUNT(4), .TOL(TOLP)) dut_a (
        .i_clk (clk), .i_rst (rst), .bus (bus_a)
    );
    tick_period_meter #(.W(W), .MAX_PERIOD(MAXP), .LOCK_COUNT(2), .TOL(TOLP)) dut_b (
        .i_clk (clk), .i_rst (rst), .bus (bus_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: timestamps of rises and a log of tick samples.
    int   lockp [2] = '{4, 2};
    int   t = 0;
    bit   tick_log [0:8191];
    bit   ptick;
    bit   m_run;
    int   m_last;
    int   m_q [$];
    bit   e_valid, e_to;
    bit   e_lock [2];
    logic [W-1:0] e_period, e_high;

    function automatic int trailing_run();
        int n = 0;
        for (int k = m_q.size() - 1; k >= 1; k--) begin
            int d = m_q[k] - m_q[k-1];
            if (d < 0) d = -d;
            if (d <= TOLP) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_reset();
        ptick = 0; m_run = 0; m_last = 0; m_q.delete();
        e_valid = 0; e_to = 0; e_lock[0] = 0; e_lock[1] = 0;
        e_period = '0; e_high = '0;
    endtask

    task automatic model_edge(input bit en_v, input bit tick_v);
        bit rise;
        int hi;
        rise = tick_v && !ptick;
        tick_log[t] = tick_v;
        e_valid = 0;
        if (!en_v) begin
            m_run = 0; m_q.delete(); e_to = 0;
            e_lock[0] = 0; e_lock[1] = 0;
        end else if (rise) begin
            if (m_run) begin
                hi = 0;
                for (int k = m_last; k < t; k++) hi += int'(tick_log[k]);
                e_period = W'(t - m_last);
                e_high   = W'(hi);
                e_valid  = 1;
                m_q.push_back(t - m_last);
                for (int i = 0; i < 2; i++) e_lock[i] = (trailing_run() >= lockp[i]);
            end
            m_run = 1; m_last = t; e_to = 0;
        end else if (m_run && (t - m_last) == MAXP) begin
            m_run = 0; e_to = 1; m_q.delete();
            e_lock[0] = 0; e_lock[1] = 0;
        end
        ptick = tick_v;
        t++;
    endtask

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] pack_a();
        return {bus_a.o_valid, bus_a.o_timeout, bus_a.o_locked, bus_a.o_period, bus_a.o_high};
    endfunction

    function automatic logic [66:0] pack_b();
        return {bus_b.o_valid, bus_b.o_timeout, bus_b.o_locked, bus_b.o_period, bus_b.o_high};
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_a"}, pack_a(), {e_valid, e_to, e_lock[0], e_period, e_high});
        check({tag, "_b"}, pack_b(), {e_valid, e_to, e_lock[1], e_period, e_high});
    endtask

    task automatic step(input logic en_v, input logic tick_v);
        bus_a.i_en = en_v; bus_a.i_tick = tick_v;
        bus_b.i_en = en_v; bus_b.i_tick = tick_v;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(en_v, tick_v);
        #1;
        compare_all("cycle");
    endtask

    task automatic pulse_period(input int p, input int h);
        for (int k = 0; k < p; k++) step(1'b1, (k < h) ? 1'b1 : 1'b0);
    endtask

    initial begin
        bus_a.i_en = 0; bus_a.i_tick = 0;
        bus_b.i_en = 0; bus_b.i_tick = 0;
        model_reset();
        repeat (3) step(1'b0, 1'b0);
        check("reset_state", pack_a(), 67'd0);
        rst = 1'b0;
        step(1'b1, 1'b0);

        // Divider n=4: single-cycle pulse every 4 cycles.
        repeat (8) pulse_period(4, 1);
        check("div4_period", 67'(bus_a.o_period), 67'd4);
        check("div4_high",   67'(bus_a.o_high),   67'd1);
        check("div4_locked", 67'(bus_a.o_locked), 67'd1);

        // Square wave 3 high / 5 low.
        repeat (5) pulse_period(8, 3);
        check("sq_period", 67'(bus_a.o_period), 67'd8);
        check("sq_high",   67'(bus_a.o_high),   67'd3);

        // Periods 10,10,10,11,10,10,10 closed by a final rise.
        repeat (3) pulse_period(10, 1);
        pulse_period(11, 1);
        repeat (3) pulse_period(10, 1);
        step(1'b1, 1'b1);
        check("relock_b", 67'(bus_b.o_locked), 67'd1);
        check("relock_a", 67'(bus_a.o_locked), 67'd0);

        // Tick stops after lock: timeout exactly MAXP cycles after the last rise.
        repeat (MAXP - 1) step(1'b1, 1'b0);
        check("pre_timeout", 67'(bus_b.o_timeout), 67'd0);
        step(1'b1, 1'b0);
        check("timeout_set", 67'({bus_b.o_timeout, bus_b.o_locked}), 67'b10);
        step(1'b1, 1'b1);
        check("timeout_clr", 67'({bus_b.o_timeout, bus_b.o_valid}), 67'b00);
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("after_to_valid", 67'({bus_b.o_valid, bus_b.o_period}), {35'd1, 32'd6});

        // Rise on the very cycle the count reaches MAXP.
        repeat (MAXP - 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("edge_max", 67'({bus_a.o_valid, bus_a.o_timeout, bus_a.o_period}), {34'b10, 32'd20});
        step(1'b1, 1'b0);

        // Async reset at cycle 2 of an 8-cycle period.
        repeat (3) pulse_period(8, 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        check("rst_period", 67'(bus_a.o_period), 67'd0);
        #1 rst = 1'b0;
        repeat (6) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("rst_recover", 67'({bus_a.o_valid, bus_a.o_period}), {35'd1, 32'd8});
        repeat (7) step(1'b1, 1'b0);

        // Enable dropped at cycle 2 of an 8-cycle period.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("en_flags", 67'({bus_a.o_valid, bus_a.o_timeout, bus_a.o_locked}), 67'd0);
        check("en_hold", 67'(bus_a.o_period), 67'd8);
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("en_recover", 67'({bus_a.o_valid, bus_a.o_period}), {35'd1, 32'd8});
        step(1'b1, 1'b0);

        // Random periods, high times and occasional enable drops.
        for (int r = 0; r < 60; r++) begin
            int p, h;
            p = $urandom_range(2, 24);
            h = $urandom_range(1, p - 1);
            if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0);
            pulse_period(p, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
